// File: rtl/spi_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_ram_arbiter
// Purpose  : Shares one single-port synchronous RAM between an SPI slave
//            command stream and a host request/grant port, using round-robin
//            arbitration on ties.
//            SPI frames use bits [9:8] as the command:
//              00 = load write address   01 = write payload
//              10 = load read address    11 = read
//            One SPI access can be pending at a time. A second access frame
//            that arrives while one is still pending is dropped, and the
//            sticky overrun flag is set.
// Ports    : clk, rst_n                    - clock, async active-low reset
//            spi_rx_valid/spi_rx_data      - SPI frame in (edge-accepted)
//            spi_tx_valid/spi_tx_data      - SPI read data out (held)
//            spi_ovf                       - sticky SPI overrun
//            host_req/we/addr/wdata        - host request (held until gnt)
//            host_gnt, host_rvalid/rdata   - host grant / read-data pulses
//            ram_en/we/addr/wdata, ram_rdata - RAM port (1-cycle read)
// Revision : 1.0 - initial release
// ============================================================================
module spi_ram_arbiter #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spi_rx_valid,
  input  logic [9:0]           spi_rx_data,
  output logic                 spi_tx_valid,
  output logic [7:0]           spi_tx_data,
  output logic                 spi_ovf,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [7:0]           host_wdata,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  output logic [7:0]           host_rdata,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [7:0]           ram_wdata,
  input  logic [7:0]           ram_rdata
);

  if (MEM_DEPTH != (1 << ADDR_SIZE)) begin : g_bad_depth
    $error("spi_ram_arbiter: MEM_DEPTH must equal 2**ADDR_SIZE");
  end

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ISSUE_SPI  = 2'd1,
    ST_ISSUE_HOST = 2'd2,
    ST_RD_WAIT    = 2'd3
  } state_t;

  state_t                 state_q;
  logic                   rx_valid_q;
  logic [ADDR_SIZE-1:0]   wr_addr_q;
  logic [ADDR_SIZE-1:0]   rd_addr_q;
  logic                   pend_q;
  logic                   pend_we_q;
  logic [ADDR_SIZE-1:0]   pend_addr_q;
  logic [7:0]             pend_data_q;
  logic                   ovf_q;
  logic                   last_host_q;
  logic                   rd_host_q;
  logic                   tx_valid_q;
  logic [7:0]             tx_data_q;
  logic                   host_gnt_q;
  logic                   host_rvalid_q;
  logic [7:0]             host_rdata_q;
  logic                   ram_en_q;
  logic                   ram_we_q;
  logic [ADDR_SIZE-1:0]   ram_addr_q;
  logic [7:0]             ram_wdata_q;

  logic                   rx_accept;
  logic [1:0]             rx_cmd;
  logic [ADDR_SIZE-1:0]   rx_payload_addr;
  logic                   rx_access;
  logic                   pend_busy;
  logic                   pend_load;
  logic                   pend_drop;
  logic                   spi_req;
  logic                   grant_spi;
  logic                   spi_we_d;
  logic [ADDR_SIZE-1:0]   spi_addr_d;
  logic [7:0]             spi_data_d;

  // Only the low-to-high transition of spi_rx_valid accepts a frame.
  assign rx_accept       = spi_rx_valid & ~rx_valid_q;
  assign rx_cmd          = spi_rx_data[9:8];
  assign rx_payload_addr = ADDR_SIZE'(spi_rx_data[7:0]);
  assign rx_access       = rx_accept & rx_cmd[0];

  // The pending slot is considered free during the ISSUE_SPI cycle, since
  // its contents are already on the RAM port and it is cleared that cycle.
  assign pend_busy = pend_q & (state_q != ST_ISSUE_SPI);
  assign pend_load = rx_access & ~pend_busy;
  assign pend_drop = rx_access &  pend_busy;

  // A frame accepted in this cycle can be issued straight from IDLE, which
  // gives the one-cycle accept-to-ram_en latency. The address is sampled
  // now so later address frames do not disturb an already-queued access.
  assign spi_req    = pend_busy | pend_load;
  assign spi_we_d   = pend_busy ? pend_we_q   : ~rx_cmd[1];
  assign spi_addr_d = pend_busy ? pend_addr_q : (rx_cmd[1] ? rd_addr_q : wr_addr_q);
  assign spi_data_d = pend_busy ? pend_data_q : spi_rx_data[7:0];

  // Round-robin: on a tie, SPI wins if the host was granted last.
  assign grant_spi = spi_req & (~host_req | last_host_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rx_valid_q    <= 1'b0;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      pend_q        <= 1'b0;
      pend_we_q     <= 1'b0;
      pend_addr_q   <= '0;
      pend_data_q   <= '0;
      ovf_q         <= 1'b0;
      last_host_q   <= 1'b1;
      rd_host_q     <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      host_gnt_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
    end else begin
      rx_valid_q    <= spi_rx_valid;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      host_gnt_q    <= 1'b0;
      host_rvalid_q <= 1'b0;

      if (rx_accept && rx_cmd == 2'b00) begin
        wr_addr_q <= rx_payload_addr;
      end
      if (rx_accept && rx_cmd == 2'b10) begin
        rd_addr_q <= rx_payload_addr;
      end

      if (pend_load) begin
        pend_q      <= 1'b1;
        pend_we_q   <= spi_we_d;
        pend_addr_q <= spi_addr_d;
        pend_data_q <= spi_data_d;
      end else if (state_q == ST_ISSUE_SPI) begin
        pend_q <= 1'b0;
      end

      if (pend_drop) begin
        ovf_q <= 1'b1;
      end

      // A new frame invalidates held read data; a read completing in the
      // same cycle (RD_WAIT below) takes priority as it carries fresh data.
      if (rx_accept) begin
        tx_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (grant_spi) begin
            state_q     <= ST_ISSUE_SPI;
            ram_en_q    <= 1'b1;
            ram_we_q    <= spi_we_d;
            ram_addr_q  <= spi_addr_d;
            ram_wdata_q <= spi_data_d;
            last_host_q <= 1'b0;
            rd_host_q   <= 1'b0;
          end else if (host_req) begin
            state_q     <= ST_ISSUE_HOST;
            ram_en_q    <= 1'b1;
            ram_we_q    <= host_we;
            ram_addr_q  <= host_addr;
            ram_wdata_q <= host_wdata;
            host_gnt_q  <= 1'b1;
            last_host_q <= 1'b1;
            rd_host_q   <= 1'b1;
          end
        end
        ST_ISSUE_SPI, ST_ISSUE_HOST: begin
          state_q <= ram_we_q ? ST_IDLE : ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (rd_host_q) begin
            host_rdata_q  <= ram_rdata;
            host_rvalid_q <= 1'b1;
          end else begin
            tx_data_q  <= ram_rdata;
            tx_valid_q <= 1'b1;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign spi_tx_valid = tx_valid_q;
  assign spi_tx_data  = tx_data_q;
  assign spi_ovf      = ovf_q;
  assign host_gnt     = host_gnt_q;
  assign host_rvalid  = host_rvalid_q;
  assign host_rdata   = host_rdata_q;
  assign ram_en       = ram_en_q;
  assign ram_we       = ram_we_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_ram_arbiter
// Purpose  : Self-checking bench for spi_ram_arbiter with a behavioural RAM,
//            a shadow memory model and scoreboard queues for RAM writes,
//            SPI read data and host read data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_ram_arbiter;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          spi_rx_valid;
  logic [9:0]    spi_rx_data;
  logic          spi_tx_valid;
  logic [7:0]    spi_tx_data;
  logic          spi_ovf;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdata;
  logic          host_gnt;
  logic          host_rvalid;
  logic [7:0]    host_rdata;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int rv_cnt   = 0;
  int lat;
  int n0;
  logic tx_prev = 1'b0;

  logic [7:0]  ram [256];
  logic [7:0]  mdl [256];
  logic [15:0] wr_q [$];
  logic [7:0]  spi_q [$];
  logic [7:0]  host_q [$];

  spi_ram_arbiter #(.MEM_DEPTH(256), .ADDR_SIZE(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi_rx_valid (spi_rx_valid),
    .spi_rx_data  (spi_rx_data),
    .spi_tx_valid (spi_tx_valid),
    .spi_tx_data  (spi_tx_data),
    .spi_ovf      (spi_ovf),
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_gnt     (host_gnt),
    .host_rvalid  (host_rvalid),
    .host_rdata   (host_rdata),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM, read data valid the cycle after the read is issued.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    wr_q.push_back({a, d});
    mdl[a] = d;
  endtask

  task automatic send_frame(input logic [9:0] f, input int hold);
    spi_rx_valid = 1'b1;
    spi_rx_data  = f;
    repeat (hold) tick();
    spi_rx_valid = 1'b0;
    tick();
  endtask

  task automatic host_access(input logic we, input logic [7:0] a, input logic [7:0] d,
                             input bit exp_rd, output int cycles);
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = a;
    host_wdata = d;
    if (we) push_wr(a, d);
    else if (exp_rd) host_q.push_back(mdl[a]);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!host_gnt && cycles < 20);
    if (!host_gnt) check_val("host_gnt_timeout", {31'd0, host_gnt}, 32'd1);
    host_req = 1'b0;
  endtask

  // Scoreboard monitor; an empty queue yields an X expectation, which
  // never matches a real DUT value.
  always @(negedge clk) begin
    logic [15:0] ew;
    logic [7:0]  ed;
    if (rst_n) begin
      if (ram_en && ram_we) begin
        wr_cnt++;
        ew = (wr_q.size() > 0) ? wr_q.pop_front() : 16'hxxxx;
        check_val("ram_write", {16'd0, ram_addr, ram_wdata}, {16'd0, ew});
      end
      if (spi_tx_valid && !tx_prev) begin
        ed = (spi_q.size() > 0) ? spi_q.pop_front() : 8'hxx;
        check_val("spi_tx_data", {24'd0, spi_tx_data}, {24'd0, ed});
      end
      if (host_rvalid) begin
        rv_cnt++;
        ed = (host_q.size() > 0) ? host_q.pop_front() : 8'hxx;
        check_val("host_rdata", {24'd0, host_rdata}, {24'd0, ed});
      end
    end
    tx_prev = spi_tx_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    spi_rx_valid = 1'b0;
    spi_rx_data  = '0;
    host_req     = 1'b0;
    host_we      = 1'b0;
    host_addr    = '0;
    host_wdata   = '0;
    ram_rdata    = '0;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'h00;
      mdl[i] = 8'h00;
    end
    rst_n = 1'b0;
    repeat (3) tick();

    // Reset state
    check_val("rst_ram_en",      {31'd0, ram_en},       32'd0);
    check_val("rst_ram_we",      {31'd0, ram_we},       32'd0);
    check_val("rst_spi_tx_valid",{31'd0, spi_tx_valid}, 32'd0);
    check_val("rst_spi_ovf",     {31'd0, spi_ovf},      32'd0);
    check_val("rst_host_gnt",    {31'd0, host_gnt},     32'd0);
    check_val("rst_host_rvalid", {31'd0, host_rvalid},  32'd0);
    check_val("rst_ram_addr",    {24'd0, ram_addr},     32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // SPI write: address frame then data frame, one-cycle latency to RAM
    send_frame(10'h005, 1);
    push_wr(8'h05, 8'hA5);
    spi_rx_valid = 1'b1;
    spi_rx_data  = 10'h1A5;
    tick();
    check_val("spi_wr_ram_en",    {31'd0, ram_en},    32'd1);
    check_val("spi_wr_ram_we",    {31'd0, ram_we},    32'd1);
    check_val("spi_wr_ram_addr",  {24'd0, ram_addr},  32'h05);
    check_val("spi_wr_ram_wdata", {24'd0, ram_wdata}, 32'hA5);
    spi_rx_valid = 1'b0;
    tick();
    check_val("spi_wr_one_cycle", {31'd0, ram_en}, 32'd0);
    tick();

    // SPI read: three-cycle latency, data held until next frame
    send_frame(10'h205, 1);
    spi_q.push_back(mdl[8'h05]);
    spi_rx_valid = 1'b1;
    spi_rx_data  = 10'h300;
    tick();
    spi_rx_valid = 1'b0;
    tick();
    check_val("spi_rd_early", {31'd0, spi_tx_valid}, 32'd0);
    tick();
    check_val("spi_rd_lat",   {31'd0, spi_tx_valid}, 32'd1);
    repeat (4) tick();
    check_val("spi_tx_hold_v", {31'd0, spi_tx_valid}, 32'd1);
    check_val("spi_tx_hold_d", {24'd0, spi_tx_data},  32'hA5);
    spi_rx_valid = 1'b1;
    spi_rx_data  = 10'h000;
    tick();
    check_val("spi_tx_clear", {31'd0, spi_tx_valid}, 32'd0);
    spi_rx_valid = 1'b0;
    tick();

    // Host write then read with latency checks
    host_access(1'b1, 8'h10, 8'h3C, 1'b1, lat);
    check_val("host_wr_gnt_lat", lat, 32'd1);
    tick();
    tick();
    host_access(1'b0, 8'h10, 8'h00, 1'b1, lat);
    check_val("host_rd_gnt_lat", lat, 32'd1);
    tick();
    check_val("host_rv_early", {31'd0, host_rvalid}, 32'd0);
    tick();
    check_val("host_rv_lat",   {31'd0, host_rvalid}, 32'd1);
    tick();

    // Tie after reset: SPI first, then host wins the following tie
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    push_wr(8'h00, 8'h77);
    host_q.push_back(mdl[8'h05]);
    spi_rx_valid = 1'b1;
    spi_rx_data  = 10'h177;
    host_req     = 1'b1;
    host_we      = 1'b0;
    host_addr    = 8'h05;
    tick();
    check_val("tie1_spi_we",  {31'd0, ram_we},   32'd1);
    check_val("tie1_no_gnt",  {31'd0, host_gnt}, 32'd0);
    spi_rx_valid = 1'b0;
    tick();
    check_val("tie1_idle_gap", {31'd0, host_gnt}, 32'd0);
    spi_rx_valid = 1'b1;
    spi_rx_data  = 10'h1BB;
    push_wr(8'h00, 8'hBB);
    tick();
    check_val("tie2_host_gnt",  {31'd0, host_gnt}, 32'd1);
    check_val("tie2_host_addr", {24'd0, ram_addr}, 32'h05);
    check_val("tie2_host_rd",   {31'd0, ram_we},   32'd0);
    host_req     = 1'b0;
    spi_rx_valid = 1'b0;
    tick();
    tick();
    tick();
    check_val("tie2_spi_after", {31'd0, ram_en & ram_we}, 32'd1);
    tick();
    tick();

    // Overrun: two access frames while a host read is in progress
    send_frame(10'h040, 1);
    check_val("ovf_clear_before", {31'd0, spi_ovf}, 32'd0);
    host_q.push_back(mdl[8'h05]);
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 8'h05;
    tick();
    check_val("ovf_host_gnt", {31'd0, host_gnt}, 32'd1);
    host_req     = 1'b0;
    spi_rx_valid = 1'b1;
    spi_rx_data  = 10'h111;
    push_wr(8'h40, 8'h11);
    tick();
    spi_rx_valid = 1'b0;
    tick();
    spi_rx_valid = 1'b1;
    spi_rx_data  = 10'h122;
    tick();
    check_val("ovf_set",        {31'd0, spi_ovf},   32'd1);
    check_val("ovf_first_kept", {24'd0, ram_wdata}, 32'h11);
    spi_rx_valid = 1'b0;
    repeat (5) tick();
    check_val("ovf_sticky", {31'd0, spi_ovf}, 32'd1);

    // Held-high frame produces exactly one write
    n0 = wr_cnt;
    push_wr(8'h40, 8'hFF);
    send_frame(10'h1FF, 5);
    repeat (5) tick();
    check_val("held_one_write", wr_cnt - n0, 32'd1);

    // Reset during a host RD_WAIT clears everything asynchronously
    send_frame(10'h205, 1);
    spi_q.push_back(mdl[8'h05]);
    send_frame(10'h300, 1);
    repeat (4) tick();
    check_val("pre_rst_tx_valid", {31'd0, spi_tx_valid}, 32'd1);
    host_access(1'b0, 8'h05, 8'h00, 1'b0, lat);
    tick();
    #2;
    n0 = rv_cnt;
    rst_n = 1'b0;
    #1;
    check_val("arst_tx_valid", {31'd0, spi_tx_valid}, 32'd0);
    check_val("arst_tx_data",  {24'd0, spi_tx_data},  32'd0);
    check_val("arst_ovf",      {31'd0, spi_ovf},      32'd0);
    check_val("arst_rvalid",   {31'd0, host_rvalid},  32'd0);
    check_val("arst_rdata",    {24'd0, host_rdata},   32'd0);
    check_val("arst_ram_addr", {24'd0, ram_addr},     32'd0);
    check_val("arst_ram_wdata",{24'd0, ram_wdata},    32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) tick();
    check_val("abort_no_rvalid", rv_cnt - n0, 32'd0);
    check_val("abort_no_tx",     {31'd0, spi_tx_valid}, 32'd0);

    check_val("wr_q_left",   wr_q.size(),   32'd0);
    check_val("spi_q_left",  spi_q.size(),  32'd0);
    check_val("host_q_left", host_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_ram_arbiter.md
SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

Interface
REQ-001 Parameter: MEM_DEPTH, 256, RAM word count.
REQ-002 Parameter: ADDR_SIZE, 8, RAM address width; MEM_DEPTH SHALL equal 2**ADDR_SIZE.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 spi_rx_valid  input  1  SPI slave frame valid; may stay high several cycles per frame.
REQ-006 spi_rx_data  input  10  SPI frame; [9:8] command, [7:0] payload.
REQ-007 spi_tx_valid  output  1  read data available to SPI slave.
REQ-008 spi_tx_data  output  8  read data to SPI slave.
REQ-009 spi_ovf  output  1  sticky SPI overrun flag.
REQ-010 host_req  input  1  host access request; held until host_gnt.
REQ-011 host_we  input  1  host write (1) / read (0); stable while host_req high.
REQ-012 host_addr  input  ADDR_SIZE  host address.
REQ-013 host_wdata  input  8  host write data.
REQ-014 host_gnt  output  1  one-cycle pulse: host access issued to RAM.
REQ-015 host_rvalid  output  1  one-cycle pulse: host_rdata valid.
REQ-016 host_rdata  output  8  host read data.
REQ-017 ram_en, ram_we  output  1 each  RAM enable / write enable.
REQ-018 ram_addr  output  ADDR_SIZE; ram_wdata  output  8; ram_rdata  input  8 (valid one cycle after read issue).

Function
REQ-019 SPI frame accepted only on rising edge of spi_rx_valid (registered previous value); a held-high level SHALL NOT re-trigger.
REQ-020 Command 2'b00: payload latched into wr_addr in the accept cycle; no RAM access.
REQ-021 Command 2'b10: payload latched into rd_addr in the accept cycle; no RAM access.
REQ-022 Command 2'b01: sets spi_pend as write of payload to wr_addr.
REQ-023 Command 2'b11: sets spi_pend as read of rd_addr; payload ignored.
REQ-024 Any accepted SPI frame SHALL clear spi_tx_valid the following cycle.
REQ-025 Accepting a 01/11 frame while spi_pend already set: frame dropped, spi_ovf set until reset.
REQ-026 States: IDLE, ISSUE_SPI, ISSUE_HOST, RD_WAIT.
REQ-027 IDLE: only spi_pend -> ISSUE_SPI; only host_req -> ISSUE_HOST; both -> requester not last granted (round-robin); none -> IDLE.
REQ-028 ISSUE_*: ram_en=1, ram_we/ram_addr/ram_wdata from selected requester, for exactly one cycle; last_grant updated.
REQ-029 ISSUE_HOST: host_gnt=1 that cycle; ISSUE_SPI: spi_pend cleared that cycle.
REQ-030 From ISSUE_*: write -> IDLE; read -> RD_WAIT.
REQ-031 RD_WAIT: ram_rdata captured; host read -> host_rdata, host_rvalid=1 for one cycle; SPI read -> spi_tx_data, spi_tx_valid=1; then IDLE.
REQ-032 spi_tx_valid/spi_tx_data SHALL hold until next accepted SPI frame (REQ-024) or reset.
REQ-033 Outside ISSUE_*: ram_en=0, ram_we=0.
REQ-034 Latency: write accept-to-ram_en 1 cycle when idle; read accept-to-spi_tx_valid 3 cycles when idle; host req-to-gnt 1 cycle, gnt-to-rvalid 2 cycles when idle.
REQ-035 SPI frame accepted during any state is queued in spi_pend; address commands (00/10) SHALL update address registers even while a RAM access is in progress, not affecting the in-flight access.
REQ-036 Worst case wait per requester: one access of the other requester (max 2 cycles).

Reset
REQ-037 rst_n low SHALL immediately force state=IDLE, all outputs 0, wr_addr=rd_addr=0, spi_pend=0, spi_ovf=0, last_grant=host (SPI wins first tie), rx_valid edge register=0.
REQ-038 Reset mid-access SHALL abort it; no host_rvalid/spi_tx_valid for the aborted read.

Verification
REQ-039 SPI 0x005 then 0x1A5 -> one cycle ram_en=1, ram_we=1, ram_addr=0x05, ram_wdata=0xA5.
REQ-040 SPI 0x205 then 0x300, RAM returns 0xA5 -> spi_tx_valid=1, spi_tx_data=0xA5 held until next frame.
REQ-041 spi_pend write and host_req read same cycle after reset -> SPI issued first, host_gnt next IDLE-exit; next tie grants host.
REQ-042 Two 01 frames back-to-back while host access in progress -> second dropped, spi_ovf=1.
REQ-043 spi_rx_valid held high 5 cycles with 0x1FF -> exactly one RAM write.
REQ-044 rst_n low during RD_WAIT -> no rvalid/tx_valid, all outputs 0 asynchronously.
